nonrd_div_param: RTL and testbench

//  Parametrised non-restoring integer divider; successor of the fixed 8-bit serial divider.

---
 rtl/nonrd_div_param.sv | 150 +++++++++++++++
 tb/tb_nonrd_div_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonrd_div_param.sv
// Parametrised non-restoring integer divider, one quotient bit per clock.
// Signed/unsigned per operation, start/busy/done handshake, divide-by-zero and overflow flags.
module nonrd_div_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CORR, S_FIN} state_t;

    state_t             state, state_nx;

    logic [WIDTH-1:0]   dvd_r, dvs_r;
    logic               mode_r;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q_reg, m_reg;
    logic [CNT_W-1:0]   count;
    logic               sign_q, sign_r;

    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH:0]     acc_sh, add_a, add_b, add_y;
    logic               add_sub;
    logic [WIDTH-1:0]   rem_mag, q_fix, r_fix;
    logic               dz_det, ovf_det;

    // State register
    always_ff @(posedge clk) begin
        if (rst_b) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: state_nx = S_ITER;
            S_ITER: if (count == CNT_W'(WIDTH - 1)) state_nx = S_CORR;
            S_CORR: state_nx = S_FIN;
            S_FIN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == S_LOAD) || (state == S_ITER) || (state == S_CORR);
        done = (state == S_FIN);
    end

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as unsigned
    always_comb begin
        dvd_neg = mode_r & dvd_r[WIDTH-1];
        dvs_neg = mode_r & dvs_r[WIDTH-1];
        dvd_abs = dvd_neg ? -dvd_r : dvd_r;
        dvs_abs = dvs_neg ? -dvs_r : dvs_r;
    end

    // Single shared adder/subtractor: ITER uses the shifted accumulator, CORR restores with +M
    always_comb begin
        acc_sh  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        add_sub = (state == S_ITER) ? ~acc[WIDTH] : 1'b0;
        add_a   = (state == S_ITER) ? acc_sh : acc;
        add_b   = {1'b0, m_reg} ^ {(WIDTH+1){add_sub}};
        add_y   = add_a + add_b + {{WIDTH{1'b0}}, add_sub};
    end

    // Remainder restore, sign fix-up and exception detection
    always_comb begin
        rem_mag = acc[WIDTH] ? add_y[WIDTH-1:0] : acc[WIDTH-1:0];
        q_fix   = sign_q ? -q_reg : q_reg;
        r_fix   = sign_r ? -rem_mag : rem_mag;
        dz_det  = (dvs_r == '0);
        ovf_det = mode_r && (dvd_r == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_r == '1);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst_b) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            mode_r      <= 1'b0;
            acc         <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_r       <= dividend;
                        dvs_r       <= divisor;
                        mode_r      <= signed_mode;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    m_reg  <= dvs_abs;
                    q_reg  <= dvd_abs;
                    acc    <= '0;
                    count  <= '0;
                    sign_q <= dvd_neg ^ dvs_neg;
                    sign_r <= dvd_neg;
                end
                S_ITER: begin
                    acc   <= add_y;
                    q_reg <= {q_reg[WIDTH-2:0], ~add_y[WIDTH]};
                    count <= count + CNT_W'(1);
                end
                S_CORR: begin
                    if (dz_det) begin
                        quotient  <= '1;
                        remainder <= dvd_r;
                    end else if (ovf_det) begin
                        quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
                        remainder <= '0;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                    div_by_zero <= dz_det;
                    overflow    <= ovf_det;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrd_div_param.sv
// Directed-vector bench for nonrd_div_param at WIDTH=8 and WIDTH=16, plus a
// reference-model sweep of random operands.
module tb_nonrd_div_param;

    logic        clk = 1'b0;
    logic        rst_b;

    logic        start8, sm8;
    logic [7:0]  dvd8, dvs8, quo8, rem8;
    logic        busy8, done8, dz8, ov8;

    logic        start16, sm16;
    logic [15:0] dvd16, dvs16, quo16, rem16;
    logic        busy16, done16, dz16, ov16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nonrd_div_param #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(quo8), .remainder(rem8), .div_by_zero(dz8), .overflow(ov8)
    );

    nonrd_div_param #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16),
        .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
        .quotient(quo16), .remainder(rem16), .div_by_zero(dz16), .overflow(ov16)
    );

    typedef struct {
        logic       sm;
        logic [7:0] a, b, q, r;
        logic       dz, ov;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called one step after a rising edge with the divider idle. Returns the
    // number of edges from start to done (-1 on timeout). busy_ok tracks the
    // busy/done handshake. A nonzero poke_at pulses start with new operands mid-run.
    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b, input int poke_at,
                       output logic [7:0] q, output logic [7:0] r, output logic dz, output logic ov,
                       output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        sm8 = sm; dvd8 = a; dvs8 = b; start8 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start8 = (n == poke_at);
            dvd8 = (n == poke_at) ? 8'd200 : ~a;
            dvs8 = (n == poke_at) ? 8'd3 : ~b;
            sm8  = ~sm;
            if (done8) begin
                if (busy8) busy_ok = 1'b0;
                lat = n;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
        end
        q = quo8; r = rem8; dz = dz8; ov = ov8;
        start8 = 1'b0;
        @(posedge clk); #1;
        if (done8 || busy8) busy_ok = 1'b0;
    endtask

    task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz, output logic ov,
                        output int lat);
        lat = -1;
        sm16 = sm; dvd16 = a; dvs16 = b; start16 = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            start16 = 1'b0;
            dvd16 = ~a; dvs16 = ~b;
            if (done16) begin
                lat = n;
                break;
            end
        end
        q = quo16; r = rem16; dz = dz16; ov = ov16;
        @(posedge clk); #1;
    endtask

    function automatic void ref_div(input int w, input logic sm, input longint a, input longint b,
                                    output longint q, output longint r, output logic dz, output logic ov);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint sa, sb;
        dz = 1'b0; ov = 1'b0;
        if (b == 0) begin
            q = mask; r = a; dz = 1'b1;
        end else if (sm) begin
            sa = (a >= half) ? a - (longint'(1) << w) : a;
            sb = (b >= half) ? b - (longint'(1) << w) : b;
            if (sa == -half && sb == -1) begin
                q = half; r = 0; ov = 1'b1;
            end else begin
                q = (sa / sb) & mask;
                r = (sa % sb) & mask;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        logic [7:0]  q, r;
        logic [15:0] q16, r16;
        logic        dz, ov, bok;
        int          lat, n_done, gap;
        longint      eq, er;
        logic        edz, eov;

        vecs[0]  = '{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h05,  8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'hFB,  8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00,  8'h05, 8'h00, 8'h00, 1'b0, 1'b0};

        rst_b = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst8_busy_done", {busy8, done8}, 0);
        check("rst8_quotient", quo8, 0);
        check("rst8_remainder", rem8, 0);
        check("rst8_flags", {dz8, ov8}, 0);
        check("rst16_all", {busy16, done16, quo16, rem16, dz16, ov16}, 0);
        rst_b = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            op8(vecs[i].sm, vecs[i].a, vecs[i].b, 0, q, r, dz, ov, lat, bok);
            check($sformatf("v%0d_quotient", i), q, vecs[i].q);
            check($sformatf("v%0d_remainder", i), r, vecs[i].r);
            check($sformatf("v%0d_flags", i), {dz, ov}, {vecs[i].dz, vecs[i].ov});
            check($sformatf("v%0d_latency", i), lat, 11);
            check($sformatf("v%0d_handshake", i), bok, 1);
        end

        // Start pulsed mid-ITER with new operands must be ignored
        op8(1'b0, 8'd100, 8'd7, 4, q, r, dz, ov, lat, bok);
        check("poke_quotient", q, 8'h0E);
        check("poke_remainder", r, 8'h02);
        check("poke_latency", lat, 11);
        check("poke_no_restart", {busy8, done8}, 0);

        // Holding start high: one operation every WIDTH+4 cycles, start in FIN ignored
        sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
        n_done = 0; gap = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n_done == 1) gap++;
            if (done8) begin
                n_done++;
                if (n_done == 1) gap = 0;
                if (n_done == 2) break;
            end
        end
        check("b2b_period", gap, 12);
        check("b2b_quotient", quo8, 8'h0E);
        start8 = 1'b0;
        @(posedge clk); #1;

        // Reset mid-operation: results cleared next edge, no done afterwards
        op8(1'b0, 8'h05, 8'h00, 0, q, r, dz, ov, lat, bok);
        sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("midrst_busy_done", {busy8, done8}, 0);
        check("midrst_results", {quo8, rem8}, 0);
        check("midrst_flags", {dz8, ov8}, 0);
        n_done = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) n_done++;
        end
        check("midrst_no_done", n_done, 0);

        // WIDTH=16 corners
        op16(1'b0, 16'd65535, 16'd255, q16, r16, dz, ov, lat);
        check("w16_quotient", q16, 16'd257);
        check("w16_remainder", r16, 16'd0);
        check("w16_latency", lat, 19);
        op16(1'b1, 16'h8000, 16'hFFFF, q16, r16, dz, ov, lat);
        check("w16_ovf", {q16, r16, dz, ov}, {16'h8000, 16'h0000, 1'b0, 1'b1});

        // Random operands against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic       rsm;
            logic [7:0] ra, rb;
            rsm = 1'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 31) == 0) begin ra = 8'h80; rb = 8'hFF; end
            op8(rsm, ra, rb, 0, q, r, dz, ov, lat, bok);
            ref_div(8, rsm, longint'(ra), longint'(rb), eq, er, edz, eov);
            check($sformatf("rand8 %0d/%0d s=%0d", ra, rb, rsm), {q, r, dz, ov, 32'(lat)},
                  {8'(eq), 8'(er), edz, eov, 32'd11});
        end
        for (int i = 0; i < 400; i++) begin
            logic        rsm;
            logic [15:0] ra, rb;
            rsm = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 15));
            op16(rsm, ra, rb, q16, r16, dz, ov, lat);
            ref_div(16, rsm, longint'(ra), longint'(rb), eq, er, edz, eov);
            check($sformatf("rand16 %0d/%0d s=%0d", ra, rb, rsm), {q16, r16, dz, ov, 32'(lat)},
                  {16'(eq), 16'(er), edz, eov, 32'd19});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
